// File: rtl/controlador_aprovados_pkg.sv
// Shared types and helpers for the approved-node sequencer: FSM encoding,
// default geometry and the saturating threshold add.
package controlador_pkg;

  localparam int BUFFER_SIZE_DEF = 16;
  localparam int DIST_WIDTH_DEF  = 8;
  localparam int NODE_WIDTH_DEF  = 8;
  localparam int THRESH_STEP_DEF = 1;
  localparam int SLOT_W          = $clog2(BUFFER_SIZE_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AVALIA,
    ST_ELEVA,
    ST_OFERECE,
    ST_REMOVE,
    ST_ESPERA,
    ST_FIM
  } estado_t;

  // a + b clamped to the all-ones value of a w-bit field; never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] soma;
    logic [32:0] max_v;
    soma  = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (soma > max_v) ? max_v[31:0] : soma[31:0];
  endfunction

endpackage

// File: rtl/controlador_aprovados_if.sv
// Evaluator / expansion-stage signal bundle of the sequencer.
// master = sequencer side, slave = evaluator and expansion stage side.
interface controlador_aprovados_if
  import controlador_pkg::*;
#(
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int DIST_WIDTH  = DIST_WIDTH_DEF,
  parameter int NODE_WIDTH  = NODE_WIDTH_DEF
);
  localparam int SEL_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  logic                   start_in;
  logic [DIST_WIDTH-1:0]  treshold_init_in;
  logic                   tem_ativo_in;
  logic [BUFFER_SIZE-1:0] aprovados_in;
  logic [SEL_W-1:0]       slot_sel_out;
  logic [NODE_WIDTH-1:0]  slot_endereco_in;
  logic [DIST_WIDTH-1:0]  treshold_out;
  logic                   expandir_valid_out;
  logic [NODE_WIDTH-1:0]  expandir_endereco_out;
  logic                   expandir_ready_in;
  logic                   remover_out;
  logic [NODE_WIDTH-1:0]  remover_endereco_out;
  logic                   ocupado_out;
  logic                   concluido_out;
  logic                   saturado_out;

  modport master (
    input  start_in, treshold_init_in, tem_ativo_in, aprovados_in, slot_endereco_in,
           expandir_ready_in,
    output slot_sel_out, treshold_out, expandir_valid_out, expandir_endereco_out,
           remover_out, remover_endereco_out, ocupado_out, concluido_out, saturado_out
  );

  modport slave (
    output start_in, treshold_init_in, tem_ativo_in, aprovados_in, slot_endereco_in,
           expandir_ready_in,
    input  slot_sel_out, treshold_out, expandir_valid_out, expandir_endereco_out,
           remover_out, remover_endereco_out, ocupado_out, concluido_out, saturado_out
  );

endinterface

// File: rtl/controlador_aprovados_rr_seletor.sv
// Round-robin picker: first set request at index >= ptr, wrapping to 0.
// Rotate right by ptr, priority-encode the lowest bit, rotate the index back.
module rr_seletor #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         hit_o
);
  localparam logic [W:0] N_W = N[W:0];

  logic [2*N-1:0] dobrado;
  logic [N-1:0]   girado;
  logic [W-1:0]   desloc;
  logic [W:0]     soma;
  logic [W:0]     soma_mod;

  assign dobrado = {req_i, req_i} >> ptr_i;
  assign girado  = dobrado[N-1:0];

  always_comb begin
    desloc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (girado[i]) begin
        desloc = W'(i);
      end
    end
  end

  assign hit_o    = |req_i;
  assign soma     = {1'b0, ptr_i} + {1'b0, desloc};
  assign soma_mod = (soma >= N_W) ? (soma - N_W) : soma;
  assign idx_o    = soma_mod[W-1:0];

endmodule

// File: rtl/controlador_aprovados.sv
// Approved-node sequencer: grants approved slots round-robin, hands them to
// expansion, removes them, and raises the threshold when nothing is approved.
// Optional statistics counters are enabled by CONTROLADOR_ESTATISTICAS_EN.
module controlador_aprovados
  import controlador_pkg::*;
#(
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int DIST_WIDTH  = DIST_WIDTH_DEF,
  parameter int NODE_WIDTH  = NODE_WIDTH_DEF,
  parameter int THRESH_STEP = THRESH_STEP_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  controlador_aprovados_if.master bus
`ifdef CONTROLADOR_ESTATISTICAS_EN
  ,
  output logic [15:0]             n_expandidos_out,
  output logic [15:0]             n_elevacoes_out
`endif
);
  localparam int SEL_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam logic [SEL_W-1:0] SLOT_ULTIMO = SEL_W'(BUFFER_SIZE - 1);

  estado_t               estado_q, estado_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [SEL_W-1:0]      slot_q, slot_d;
  logic [NODE_WIDTH-1:0] addr_q, addr_d;
  logic [DIST_WIDTH-1:0] treshold_q, treshold_d;
  logic                  saturado_q, saturado_d;

  logic [SEL_W-1:0]      pick_idx;
  logic                  pick_hit;
  logic [31:0]           soma;
  logic [DIST_WIDTH-1:0] elevado;
  logic                  handshake;

  rr_seletor #(
    .N (BUFFER_SIZE),
    .W (SEL_W)
  ) u_rr (
    .req_i (bus.aprovados_in),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .hit_o (pick_hit)
  );

  assign soma      = sat_add(32'(treshold_q), 32'(THRESH_STEP), DIST_WIDTH);
  assign elevado   = soma[DIST_WIDTH-1:0];
  assign handshake = (estado_q == ST_OFERECE) && bus.expandir_ready_in;

  always_comb begin
    estado_d   = estado_q;
    ptr_d      = ptr_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    treshold_d = treshold_q;
    saturado_d = saturado_q;
    unique case (estado_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          treshold_d = bus.treshold_init_in;
          saturado_d = 1'b0;
          estado_d   = ST_AVALIA;
        end
      end
      ST_AVALIA: begin
        if (!bus.tem_ativo_in) begin
          estado_d = ST_FIM;
        end else if (pick_hit) begin
          // slot_sel_out already points at pick_idx, so the lookup is the granted address
          slot_d   = pick_idx;
          addr_d   = bus.slot_endereco_in;
          estado_d = ST_OFERECE;
        end else begin
          estado_d = ST_ELEVA;
        end
      end
      ST_ELEVA: begin
        treshold_d = elevado;
        if (&elevado) begin
          saturado_d = 1'b1;
        end
        estado_d = ST_AVALIA;
      end
      ST_OFERECE: begin
        if (handshake) begin
          ptr_d    = (slot_q == SLOT_ULTIMO) ? '0 : slot_q + 1'b1;
          estado_d = ST_REMOVE;
        end
      end
      ST_REMOVE: estado_d = ST_ESPERA;
      ST_ESPERA: estado_d = ST_AVALIA;
      ST_FIM:    estado_d = ST_IDLE;
      default:   estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      estado_q   <= ST_IDLE;
      ptr_q      <= '0;
      slot_q     <= '0;
      addr_q     <= '0;
      treshold_q <= '0;
      saturado_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ptr_q      <= ptr_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      treshold_q <= treshold_d;
      saturado_q <= saturado_d;
    end
  end

  assign bus.slot_sel_out          = (estado_q == ST_AVALIA) ? pick_idx : slot_q;
  assign bus.treshold_out          = treshold_q;
  assign bus.expandir_valid_out    = (estado_q == ST_OFERECE);
  assign bus.expandir_endereco_out = addr_q;
  assign bus.remover_out           = (estado_q == ST_REMOVE);
  assign bus.remover_endereco_out  = addr_q;
  assign bus.ocupado_out           = (estado_q != ST_IDLE);
  assign bus.concluido_out         = (estado_q == ST_FIM);
  assign bus.saturado_out          = saturado_q;

`ifdef CONTROLADOR_ESTATISTICAS_EN
  logic [15:0] n_exp_q, n_elev_q;

  // Cleared only by an accepted start; a start while busy is ignored entirely.
  always_ff @(posedge clk_in) begin
    if (rst_in || (estado_q == ST_IDLE && bus.start_in)) begin
      n_exp_q  <= '0;
      n_elev_q <= '0;
    end else begin
      if (handshake && (n_exp_q != 16'hFFFF)) begin
        n_exp_q <= n_exp_q + 16'd1;
      end
      if ((estado_q == ST_ELEVA) && (n_elev_q != 16'hFFFF)) begin
        n_elev_q <= n_elev_q + 16'd1;
      end
    end
  end

  assign n_expandidos_out = n_exp_q;
  assign n_elevacoes_out  = n_elev_q;
`endif

endmodule

// File: tb/tb_controlador_aprovados.sv
// Directed bench for controlador_aprovados: grant, round robin, threshold
// raise and saturation, back-pressure, and mid-run reset.
module tb_controlador_aprovados;
  import controlador_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  controlador_aprovados_if bus ();

`ifdef CONTROLADOR_ESTATISTICAS_EN
  logic [15:0] n_exp;
  logic [15:0] n_elev;
`endif

  controlador_aprovados dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
`ifdef CONTROLADOR_ESTATISTICAS_EN
    ,
    .n_expandidos_out (n_exp),
    .n_elevacoes_out  (n_elev)
`endif
  );

  // Evaluator address lookup: slot i holds node 8'h26 + i (slot 4 -> 8'h2A).
  assign bus.slot_endereco_in = 8'h26 + 8'(bus.slot_sel_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start_in          = 1'b0;
    bus.treshold_init_in  = 8'd0;
    bus.tem_ativo_in      = 1'b0;
    bus.aprovados_in      = 16'h0000;
    bus.expandir_ready_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid",    32'(bus.expandir_valid_out), 32'd0);
    chk("rst_remover",  32'(bus.remover_out), 32'd0);
    chk("rst_ocupado",  32'(bus.ocupado_out), 32'd0);
    chk("rst_treshold", 32'(bus.treshold_out), 32'd0);
    chk("rst_concl",    32'(bus.concluido_out), 32'd0);
    rst = 1'b0;

    // 1: single grant, slot 4 -> node 2A
    bus.treshold_init_in  = 8'd5;
    bus.tem_ativo_in      = 1'b1;
    bus.aprovados_in      = 16'h0010;
    bus.expandir_ready_in = 1'b1;
    bus.start_in          = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("t1_ocupado",  32'(bus.ocupado_out), 32'd1);
    chk("t1_treshold", 32'(bus.treshold_out), 32'd5);
    chk("t1_valid_av", 32'(bus.expandir_valid_out), 32'd0);
    tick();
    chk("t1_valid",    32'(bus.expandir_valid_out), 32'd1);
    chk("t1_addr",     32'(bus.expandir_endereco_out), 32'h2A);
    chk("t1_slot",     32'(bus.slot_sel_out), 32'd4);
    tick();
    chk("t1_remover",  32'(bus.remover_out), 32'd1);
    chk("t1_rem_addr", 32'(bus.remover_endereco_out), 32'h2A);
    chk("t1_valid_rm", 32'(bus.expandir_valid_out), 32'd0);
    bus.tem_ativo_in = 1'b0;
    bus.aprovados_in = 16'h0000;
    tick();
    chk("t1_rem_once", 32'(bus.remover_out), 32'd0);
    tick();
    chk("t1_concl_av", 32'(bus.concluido_out), 32'd0);
    tick();
    chk("t1_concl",    32'(bus.concluido_out), 32'd1);
    tick();
    chk("t1_concl_1c", 32'(bus.concluido_out), 32'd0);
    chk("t1_idle",     32'(bus.ocupado_out), 32'd0);
    chk("t1_thr_hold", 32'(bus.treshold_out), 32'd5);

    // 2: round robin from ptr 0 over 16'h8001: 0, 15, 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.tem_ativo_in = 1'b1;
    bus.aprovados_in = 16'h8001;
    bus.start_in     = 1'b1;
    tick();
    bus.start_in = 1'b0;
    tick();
    chk("t2_g0_valid", 32'(bus.expandir_valid_out), 32'd1);
    chk("t2_g0_slot",  32'(bus.slot_sel_out), 32'd0);
    chk("t2_g0_addr",  32'(bus.expandir_endereco_out), 32'h26);
    tick();
    tick();
    tick();
    tick();
    chk("t2_g1_slot",  32'(bus.slot_sel_out), 32'd15);
    chk("t2_g1_addr",  32'(bus.expandir_endereco_out), 32'h35);
    tick();
    tick();
    tick();
    tick();
    chk("t2_g2_slot",  32'(bus.slot_sel_out), 32'd0);
    chk("t2_g2_addr",  32'(bus.expandir_endereco_out), 32'h26);
    tick();
    bus.tem_ativo_in = 1'b0;
    bus.aprovados_in = 16'h0000;
    tick();
    tick();
    tick();
    chk("t2_concl",    32'(bus.concluido_out), 32'd1);
    tick();

    // 3: threshold 3 -> 6 in three raises, then slot 2 (ptr is 1)
    bus.treshold_init_in = 8'd3;
    bus.tem_ativo_in     = 1'b1;
    bus.start_in         = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("t3_thr3", 32'(bus.treshold_out), 32'd3);
    tick();
    tick();
    chk("t3_thr4", 32'(bus.treshold_out), 32'd4);
    tick();
    tick();
    chk("t3_thr5", 32'(bus.treshold_out), 32'd5);
    tick();
    tick();
    chk("t3_thr6", 32'(bus.treshold_out), 32'd6);
    chk("t3_valid_no", 32'(bus.expandir_valid_out), 32'd0);
    bus.aprovados_in = 16'h0004;
    tick();
    chk("t3_valid", 32'(bus.expandir_valid_out), 32'd1);
    chk("t3_slot",  32'(bus.slot_sel_out), 32'd2);
    chk("t3_addr",  32'(bus.expandir_endereco_out), 32'h28);
    chk("t3_thr_k", 32'(bus.treshold_out), 32'd6);
    chk("t3_sat",   32'(bus.saturado_out), 32'd0);
    tick();
    bus.tem_ativo_in = 1'b0;
    bus.aprovados_in = 16'h0000;
    tick();
    tick();
    tick();
    tick();

    // 4: saturation FE -> FF -> FF, sticky flag
    bus.treshold_init_in = 8'hFE;
    bus.tem_ativo_in     = 1'b1;
    bus.start_in         = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("t4_sat0", 32'(bus.saturado_out), 32'd0);
    tick();
    tick();
    chk("t4_thr1", 32'(bus.treshold_out), 32'hFF);
    chk("t4_sat1", 32'(bus.saturado_out), 32'd1);
    tick();
    tick();
    chk("t4_thr2", 32'(bus.treshold_out), 32'hFF);
    bus.tem_ativo_in = 1'b0;
    tick();
    chk("t4_concl", 32'(bus.concluido_out), 32'd1);
    tick();
    chk("t4_sat_sticky", 32'(bus.saturado_out), 32'd1);
    chk("t4_thr_hold",   32'(bus.treshold_out), 32'hFF);

    // 5: back-pressure while aprovados toggles; busy start ignored (ptr is 3)
    bus.treshold_init_in  = 8'd5;
    bus.tem_ativo_in      = 1'b1;
    bus.aprovados_in      = 16'h0010;
    bus.expandir_ready_in = 1'b0;
    bus.start_in          = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("t5_sat_clr", 32'(bus.saturado_out), 32'd0);
    tick();
    chk("t5_valid", 32'(bus.expandir_valid_out), 32'd1);
    chk("t5_addr",  32'(bus.expandir_endereco_out), 32'h2A);
    for (int i = 0; i < 4; i++) begin
      bus.aprovados_in     = (i % 2 == 0) ? 16'h0100 : 16'h0010;
      bus.treshold_init_in = 8'h77;
      bus.start_in         = (i == 1);
      tick();
      bus.start_in = 1'b0;
      chk("t5_hold_valid", 32'(bus.expandir_valid_out), 32'd1);
      chk("t5_hold_addr",  32'(bus.expandir_endereco_out), 32'h2A);
      chk("t5_no_remover", 32'(bus.remover_out), 32'd0);
      chk("t5_thr_busy",   32'(bus.treshold_out), 32'd5);
    end
    bus.expandir_ready_in = 1'b1;
    tick();
    chk("t5_remover", 32'(bus.remover_out), 32'd1);
    chk("t5_rem_addr", 32'(bus.remover_endereco_out), 32'h2A);

    // 6: reset during OFERECE (ptr 5, wraps to slot 0)
    bus.aprovados_in      = 16'h0001;
    bus.expandir_ready_in = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_valid", 32'(bus.expandir_valid_out), 32'd1);
    chk("t6_addr",  32'(bus.expandir_endereco_out), 32'h26);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid",   32'(bus.expandir_valid_out), 32'd0);
    chk("t6_rst_addr",    32'(bus.expandir_endereco_out), 32'd0);
    chk("t6_rst_ocupado", 32'(bus.ocupado_out), 32'd0);
    chk("t6_rst_thr",     32'(bus.treshold_out), 32'd0);
    chk("t6_rst_remover", 32'(bus.remover_out), 32'd0);
    chk("t6_rst_concl",   32'(bus.concluido_out), 32'd0);
    bus.tem_ativo_in = 1'b0;
    bus.start_in     = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("t6_busy", 32'(bus.ocupado_out), 32'd1);
    tick();
    chk("t6_concl", 32'(bus.concluido_out), 32'd1);
    tick();
    chk("t6_idle",  32'(bus.ocupado_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
